// File: rtl/tpu_instr_dispatch.sv
// Streams one thread's instruction block from MPU thread memory to a TPU front end.
// Optional termination watchdog: define TPU_DISPATCH_TIMEOUT_EN.
module tpu_instr_dispatch #(
  parameter int INSTR_WIDTH    = 64,
  parameter int ISSUE_NO_WIDTH = 8,
  parameter int LEN_WIDTH      = 10,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      I_Start,
  input  logic [ISSUE_NO_WIDTH-1:0] I_IssueNo,
  input  logic [LEN_WIDTH-1:0]      I_Length,
  output logic                      O_Busy,
  output logic                      O_Rd_Req,
  output logic [LEN_WIDTH-1:0]      O_Rd_Address,
  input  logic [INSTR_WIDTH-1:0]    I_Rd_Instr,
  output logic                      O_Req,
  output logic [ISSUE_NO_WIDTH-1:0] O_IssueNo,
  output logic [INSTR_WIDTH-1:0]    O_Instr,
  input  logic                      I_Nack,
  input  logic                      I_Term,
  input  logic [ISSUE_NO_WIDTH-1:0] I_Term_IssueNo,
  output logic                      O_Done,
  output logic [ISSUE_NO_WIDTH-1:0] O_Done_IssueNo,
  output logic                      O_Error
);

  typedef enum logic [1:0] {IDLE, FILL, STREAM, WAIT_TERM} state_t;

  state_t state_reg, state_next;

  logic                      o_busy_reg, o_busy_next;
  logic                      o_rd_req_reg, o_rd_req_next;
  logic [LEN_WIDTH-1:0]      o_rd_address_reg, o_rd_address_next;
  logic                      o_req_reg, o_req_next;
  logic [ISSUE_NO_WIDTH-1:0] o_issue_no_reg, o_issue_no_next;
  logic [INSTR_WIDTH-1:0]    o_instr_reg, o_instr_next;
  logic                      o_done_reg, o_done_next;
  logic [ISSUE_NO_WIDTH-1:0] o_done_issue_no_reg, o_done_issue_no_next;
  logic                      o_error_reg, o_error_next;

  logic [LEN_WIDTH-1:0]      len_reg, len_next;
  logic [LEN_WIDTH-1:0]      rd_cnt_reg, rd_cnt_next;
  logic [LEN_WIDTH-1:0]      beat_cnt_reg, beat_cnt_next;
  logic                      term_seen_reg, term_seen_next;
  logic                      inflight_reg, inflight_next;

  logic [INSTR_WIDTH-1:0]    fifo_mem [0:1];
  logic [1:0]                fifo_count_reg, fifo_count_next;
  logic                      wr_ptr_reg, wr_ptr_next;
  logic                      rd_ptr_reg, rd_ptr_next;

  logic                      pop;
  logic                      term_hit;
  logic                      fifo_push;
  logic                      fifo_pop;
  logic [2:0]                occ_next;

`ifdef TPU_DISPATCH_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] timeout_cnt_reg, timeout_cnt_next;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next           = state_reg;
    o_busy_next          = o_busy_reg;
    o_rd_req_next        = 1'b0;
    o_rd_address_next    = o_rd_address_reg;
    o_req_next           = o_req_reg;
    o_issue_no_next      = o_issue_no_reg;
    o_instr_next         = o_instr_reg;
    o_done_next          = 1'b0;
    o_done_issue_no_next = o_done_issue_no_reg;
    o_error_next         = 1'b0;
    len_next             = len_reg;
    rd_cnt_next          = rd_cnt_reg;
    beat_cnt_next        = beat_cnt_reg;
    term_seen_next       = term_seen_reg;
    inflight_next        = o_rd_req_reg;
    fifo_push            = 1'b0;
    fifo_pop             = 1'b0;
`ifdef TPU_DISPATCH_TIMEOUT_EN
    timeout_cnt_next     = timeout_cnt_reg;
`endif

    pop      = o_req_reg && !I_Nack;
    term_hit = I_Term && (I_Term_IssueNo == o_issue_no_reg);

    // The head beat lives in the output register; the FIFO only backs it up.
    if (!o_req_reg || pop) begin
      if (fifo_count_reg != 2'd0) begin
        o_instr_next = fifo_mem[rd_ptr_reg];
        o_req_next   = 1'b1;
        fifo_pop     = 1'b1;
        fifo_push    = inflight_reg;
      end else if (inflight_reg) begin
        o_instr_next = I_Rd_Instr;
        o_req_next   = 1'b1;
      end else begin
        o_req_next   = 1'b0;
      end
    end else begin
      fifo_push = inflight_reg;
    end

    fifo_count_next = fifo_count_reg + {1'b0, fifo_push} - {1'b0, fifo_pop};
    wr_ptr_next     = wr_ptr_reg ^ fifo_push;
    rd_ptr_next     = rd_ptr_reg ^ fifo_pop;
    // Data held after this edge plus the read whose data lands next cycle.
    occ_next        = {2'b00, o_req_next} + {1'b0, fifo_count_next} + {2'b00, o_rd_req_reg};

    if (pop) beat_cnt_next = beat_cnt_reg + LEN_WIDTH'(1);

    case (state_reg)
      IDLE: begin
        o_busy_next = 1'b0;
        if (I_Start && !o_busy_reg) begin
          if (I_Length == '0) begin
            o_done_next          = 1'b1;
            o_error_next         = 1'b1;
            o_done_issue_no_next = I_IssueNo;
          end else begin
            state_next        = FILL;
            o_busy_next       = 1'b1;
            o_issue_no_next   = I_IssueNo;
            len_next          = I_Length;
            o_rd_req_next     = 1'b1;
            o_rd_address_next = '0;
            rd_cnt_next       = LEN_WIDTH'(1);
            beat_cnt_next     = '0;
            term_seen_next    = 1'b0;
          end
        end
      end

      FILL, STREAM: begin
        if (term_hit) term_seen_next = 1'b1;
        if (occ_next < 3'd3 && rd_cnt_reg < len_reg) begin
          o_rd_req_next     = 1'b1;
          o_rd_address_next = rd_cnt_reg;
          rd_cnt_next       = rd_cnt_reg + LEN_WIDTH'(1);
        end
        if (state_reg == FILL) begin
          if (o_req_next) state_next = STREAM;
        end else if (pop && beat_cnt_reg == len_reg - LEN_WIDTH'(1)) begin
          if (term_seen_reg || term_hit) begin
            state_next           = IDLE;
            o_done_next          = 1'b1;
            o_done_issue_no_next = o_issue_no_reg;
          end else begin
            state_next = WAIT_TERM;
`ifdef TPU_DISPATCH_TIMEOUT_EN
            timeout_cnt_next = '0;
`endif
          end
        end
      end

      WAIT_TERM: begin
        if (term_hit) begin
          state_next           = IDLE;
          o_done_next          = 1'b1;
          o_done_issue_no_next = o_issue_no_reg;
        end
`ifdef TPU_DISPATCH_TIMEOUT_EN
        else if (timeout_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1)) begin
          state_next           = IDLE;
          o_done_next          = 1'b1;
          o_error_next         = 1'b1;
          o_done_issue_no_next = o_issue_no_reg;
        end else begin
          timeout_cnt_next = timeout_cnt_reg + TO_W'(1);
        end
`endif
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      o_busy_reg          <= 1'b0;
      o_rd_req_reg        <= 1'b0;
      o_rd_address_reg    <= '0;
      o_req_reg           <= 1'b0;
      o_issue_no_reg      <= '0;
      o_instr_reg         <= '0;
      o_done_reg          <= 1'b0;
      o_done_issue_no_reg <= '0;
      o_error_reg         <= 1'b0;
      len_reg             <= '0;
      rd_cnt_reg          <= '0;
      beat_cnt_reg        <= '0;
      term_seen_reg       <= 1'b0;
      inflight_reg        <= 1'b0;
      fifo_count_reg      <= 2'd0;
      wr_ptr_reg          <= 1'b0;
      rd_ptr_reg          <= 1'b0;
`ifdef TPU_DISPATCH_TIMEOUT_EN
      timeout_cnt_reg     <= '0;
`endif
    end else begin
      o_busy_reg          <= o_busy_next;
      o_rd_req_reg        <= o_rd_req_next;
      o_rd_address_reg    <= o_rd_address_next;
      o_req_reg           <= o_req_next;
      o_issue_no_reg      <= o_issue_no_next;
      o_instr_reg         <= o_instr_next;
      o_done_reg          <= o_done_next;
      o_done_issue_no_reg <= o_done_issue_no_next;
      o_error_reg         <= o_error_next;
      len_reg             <= len_next;
      rd_cnt_reg          <= rd_cnt_next;
      beat_cnt_reg        <= beat_cnt_next;
      term_seen_reg       <= term_seen_next;
      inflight_reg        <= inflight_next;
      fifo_count_reg      <= fifo_count_next;
      wr_ptr_reg          <= wr_ptr_next;
      rd_ptr_reg          <= rd_ptr_next;
`ifdef TPU_DISPATCH_TIMEOUT_EN
      timeout_cnt_reg     <= timeout_cnt_next;
`endif
    end
  end

  // Storage only; validity is tracked by fifo_count_reg, so no reset needed.
  always_ff @(posedge clock) begin
    if (fifo_push) fifo_mem[wr_ptr_reg] <= I_Rd_Instr;
  end

  assign O_Busy         = o_busy_reg;
  assign O_Rd_Req       = o_rd_req_reg;
  assign O_Rd_Address   = o_rd_address_reg;
  assign O_Req          = o_req_reg;
  assign O_IssueNo      = o_issue_no_reg;
  assign O_Instr        = o_instr_reg;
  assign O_Done         = o_done_reg;
  assign O_Done_IssueNo = o_done_issue_no_reg;
  assign O_Error        = o_error_reg;

endmodule
